// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: state encoding and slot-index sizing used by
// both the transmit multiplexer and the receive demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter with enable, synchronous load-to-1 and clear.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = idx_width(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load_one,
  input  logic          clr,
  output logic [IW-1:0] ch_idx,
  output logic          last_slot
);

  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  assign last_slot = (ch_idx == LAST);

  // Explicit wrap at NCH-1 keeps non-power-of-2 NCH from reaching NCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ch_idx <= '0;
    else if (clr)      ch_idx <= '0;
    else if (load_one) ch_idx <= ONE;
    else if (en)       ch_idx <= last_slot ? '0 : ch_idx + ONE;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks to frame sync, assembles a frame in a
// shadow buffer and publishes it atomically with a one-cycle frame_valid.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int IW  = idx_width(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sync,
  output logic [NCH*W-1:0] dout,
  output logic           frame_valid,
  output logic [IW-1:0]  ch_idx,
  output logic           locked,
  output logic           sync_err
);

  tdm_state_t   state;
  logic [W-1:0] shadow [NCH];
  logic         cnt_en;
  logic         cnt_load;
  logic         cnt_clr;
  logic         last_slot;

  assign cnt_load = din_valid & sync;
  assign cnt_en   = din_valid & (state == LOCKED) & ~sync & (ch_idx != '0);
  assign cnt_clr  = din_valid & (state == LOCKED) & ~sync & (ch_idx == '0);
  assign locked   = (state == LOCKED);

  tdm_slot_counter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .load_one  (cnt_load),
    .clr       (cnt_clr),
    .ch_idx    (ch_idx),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) shadow[k] <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (sync) begin
            shadow[0] <= din;
            state     <= LOCKED;
          end
        end else if (sync) begin
          // Early sync restarts the frame; expected sync is the normal slot 0.
          shadow[0] <= din;
          if (ch_idx != '0) sync_err <= 1'b1;
        end else if (ch_idx == '0) begin
          sync_err <= 1'b1;
          state    <= HUNT;
        end else begin
          for (int unsigned k = 1; k < NCH; k++)
            if (IW'(k) == ch_idx) shadow[k] <= din;
          if (last_slot) begin
            // Last word bypasses the shadow so the whole frame lands in one edge.
            for (int unsigned k = 0; k < NCH - 1; k++) dout[k*W +: W] <= shadow[k];
            dout[(NCH-1)*W +: W] <= din;
            frame_valid          <= 1'b1;
          end
        end
      end
    end
  end

endmodule
